// File: rtl/tube_pkg.sv
// ============================================================================
// Module  : tube_pkg
// Purpose : Shared definitions for the Tube register-3 transfer controller:
//           transfer type codes, sequencer state encoding, the decoded-type
//           record and a saturating byte-counter helper.
// Ports   : none (package)
// Config  : TUBE_R3_BLOCK_COUNT_EN (consumed by tube_r3_xfer_ctrl)
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package tube_pkg;

  // Transfer types as written by the host into the register-3 config strobe.
  localparam logic [2:0] XFER_P2H1    = 3'd0;
  localparam logic [2:0] XFER_H2P1    = 3'd1;
  localparam logic [2:0] XFER_P2H2    = 3'd2;
  localparam logic [2:0] XFER_H2P2    = 3'd3;
  localparam logic [2:0] XFER_EXEC    = 3'd4;
  localparam logic [2:0] XFER_ILLEGAL = 3'd5;
  localparam logic [2:0] XFER_P2H256  = 3'd6;
  localparam logic [2:0] XFER_H2P256  = 3'd7;

  localparam int unsigned CNT_W   = 9;
  localparam logic [CNT_W-1:0] CNT_MAX = 9'd511;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_EXEC = 2'd2
  } state_e;

  typedef struct packed {
    logic   one_byte_mode;
    logic   dir_h2p;
    state_e nxt_state;
    logic   is_block;
  } type_dec_t;

  // Byte counter increment that sticks at the top of its range.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 9'd1;
  endfunction

endpackage : tube_pkg

`default_nettype wire

// File: rtl/tube_r3_type_dec.sv
// ============================================================================
// Module  : tube_r3_type_dec
// Purpose : Combinational decode of a register-3 transfer type into FIFO byte
//           mode, transfer direction, the sequencer's next state and whether
//           the transfer is a counted block transfer.
// Ports   : type_i [2:0]  transfer type written by the host
//           dec_o         decoded record (type_dec_t)
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tube_r3_type_dec
  import tube_pkg::*;
(
  input  logic [2:0] type_i,
  output type_dec_t  dec_o
);

  always_comb begin
    dec_o.one_byte_mode = 1'b1;
    dec_o.dir_h2p       = type_i[0];  // odd types move host -> parasite
    dec_o.nxt_state     = ST_RUN;
    dec_o.is_block      = 1'b0;
    case (type_i)
      XFER_P2H1, XFER_H2P1: begin
        dec_o.one_byte_mode = 1'b1;
      end
      XFER_P2H2, XFER_H2P2: begin
        dec_o.one_byte_mode = 1'b0;
      end
      XFER_EXEC: begin
        dec_o.nxt_state = ST_EXEC;
      end
      XFER_ILLEGAL: begin
        dec_o.nxt_state = ST_IDLE;
      end
      XFER_P2H256, XFER_H2P256: begin
        dec_o.is_block = 1'b1;
      end
      default: begin
        dec_o.nxt_state = ST_IDLE;
      end
    endcase
  end

endmodule : tube_r3_type_dec

`default_nettype wire

// File: rtl/tube_r3_xfer_ctrl.sv
// ============================================================================
// Module  : tube_r3_xfer_ctrl
// Purpose : Host-clocked sequencer for the Tube register-3 data channel.
//           Decodes host transfer-type writes, drives FIFO byte mode and
//           direction, raises the parasite NMI when the FIFO needs service,
//           counts host-side bytes and signals block completion.
//           All state updates on the falling edge of h_phi2.
// Ports   : h_phi2        host clock (falling-edge active)
//           h_rst_b       asynchronous active-low reset
//           h_cfg_we      transfer-type write strobe
//           h_cfg_type    transfer type 0..7
//           h_abort       terminate active transfer
//           h_r3_sel      host register-3 access this cycle
//           h_we_b        host access direction (0 = write)
//           h2p_p_avail   H->P FIFO data available (parasite view)
//           p2h_p_full    P->H FIFO full (parasite view)
//           one_byte_mode FIFO byte mode
//           dir_h2p       1 = host->parasite
//           p_nmi         parasite NMI request
//           busy          transfer in progress
//           done          one-cycle block completion pulse
//           byte_cnt      bytes moved in current transfer (saturating)
// Config  : TUBE_R3_BLOCK_COUNT_EN enables block counting / auto-completion
//           for types 6 and 7. Undefined: those types run like 0/1 and
//           done stays low.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tube_r3_xfer_ctrl
  import tube_pkg::*;
#(
  parameter int BLOCK_LEN = 256
) (
  input  logic       h_phi2,
  input  logic       h_rst_b,
  input  logic       h_cfg_we,
  input  logic [2:0] h_cfg_type,
  input  logic       h_abort,
  input  logic       h_r3_sel,
  input  logic       h_we_b,
  input  logic       h2p_p_avail,
  input  logic       p2h_p_full,
  output logic       one_byte_mode,
  output logic       dir_h2p,
  output logic       p_nmi,
  output logic       busy,
  output logic       done,
  output logic [8:0] byte_cnt
);

`ifdef TUBE_R3_BLOCK_COUNT_EN
  localparam logic BLOCK_COUNT_EN = 1'b1;
`else
  localparam logic BLOCK_COUNT_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] BLOCK_LEN_C = CNT_W'(BLOCK_LEN);

  type_dec_t dec;

  tube_r3_type_dec u_type_dec (
    .type_i (h_cfg_type),
    .dec_o  (dec)
  );

  state_e           state_q, state_d;
  logic             obm_q, obm_d;
  logic             dir_q, dir_d;
  logic             blk_q, blk_d;
  logic             nmi_q, nmi_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             acc_ok;

  // A counting access must travel the same way as the transfer:
  // writes (h_we_b=0) for H->P, reads (h_we_b=1) for P->H.
  assign acc_ok = h_r3_sel && (h_we_b != dir_q);

  always_comb begin
    state_d = state_q;
    obm_d   = obm_q;
    dir_d   = dir_q;
    blk_d   = blk_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;

    if (h_abort) begin
      // Abort overrides a simultaneous type write or access; count is kept.
      state_d = ST_IDLE;
    end else if (h_cfg_we) begin
      state_d = dec.nxt_state;
      obm_d   = dec.one_byte_mode;
      dir_d   = dec.dir_h2p;
      blk_d   = dec.is_block;
      cnt_d   = '0;
    end else if ((state_q == ST_RUN) && acc_ok) begin
      cnt_d = sat_inc(cnt_q);
      // The final byte and completion land on the same edge.
      if (BLOCK_COUNT_EN && blk_q && (cnt_d == BLOCK_LEN_C)) begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
    end

    busy_d = (state_d == ST_RUN);
    // NMI is qualified with the state being entered so it drops on the same
    // edge the sequencer leaves RUN, while tracking the FIFO flags a cycle late.
    if (state_d == ST_RUN) begin
      nmi_d = dir_d ? h2p_p_avail : !p2h_p_full;
    end else begin
      nmi_d = 1'b0;
    end
  end

  always_ff @(negedge h_phi2 or negedge h_rst_b) begin
    if (!h_rst_b) begin
      state_q <= ST_IDLE;
      obm_q   <= 1'b1;
      dir_q   <= 1'b0;
      blk_q   <= 1'b0;
      nmi_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      obm_q   <= obm_d;
      dir_q   <= dir_d;
      blk_q   <= blk_d;
      nmi_q   <= nmi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign one_byte_mode = obm_q;
  assign dir_h2p       = dir_q;
  assign p_nmi         = nmi_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign byte_cnt      = cnt_q;

endmodule : tube_r3_xfer_ctrl

`default_nettype wire

// File: tb/tb_tube_r3_xfer_ctrl.sv
// ============================================================================
// Module  : tb_tube_r3_xfer_ctrl
// Purpose : Self-checking bench for tube_r3_xfer_ctrl: a table of single-cycle
//           vectors followed by hand-written multi-cycle sequences (block
//           completion or non-completion, saturation, abort, async reset).
// Config  : TUBE_R3_BLOCK_COUNT_EN selects the block-completion expectations.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tube_r3_xfer_ctrl;

  logic       h_phi2 = 1'b1;
  logic       h_rst_b;
  logic       h_cfg_we;
  logic [2:0] h_cfg_type;
  logic       h_abort;
  logic       h_r3_sel;
  logic       h_we_b;
  logic       h2p_p_avail;
  logic       p2h_p_full;
  logic       one_byte_mode;
  logic       dir_h2p;
  logic       p_nmi;
  logic       busy;
  logic       done;
  logic [8:0] byte_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 h_phi2 = ~h_phi2;

  tube_r3_xfer_ctrl #(.BLOCK_LEN(256)) dut (
    .h_phi2        (h_phi2),
    .h_rst_b       (h_rst_b),
    .h_cfg_we      (h_cfg_we),
    .h_cfg_type    (h_cfg_type),
    .h_abort       (h_abort),
    .h_r3_sel      (h_r3_sel),
    .h_we_b        (h_we_b),
    .h2p_p_avail   (h2p_p_avail),
    .p2h_p_full    (p2h_p_full),
    .one_byte_mode (one_byte_mode),
    .dir_h2p       (dir_h2p),
    .p_nmi         (p_nmi),
    .busy          (busy),
    .done          (done),
    .byte_cnt      (byte_cnt)
  );

  typedef struct {
    logic       we;
    logic [2:0] typ;
    logic       ab;
    logic       sel;
    logic       web;
    logic       av;
    logic       fu;
    logic       e_obm;
    logic       chk_obm;
    logic       e_dir;
    logic       e_nmi;
    logic       e_busy;
    logic       e_done;
    int         e_cnt;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [2:0] t, input logic ab,
                       input logic sel, input logic web, input logic av,
                       input logic fu);
    h_cfg_we    = we;
    h_cfg_type  = t;
    h_abort     = ab;
    h_r3_sel    = sel;
    h_we_b      = web;
    h2p_p_avail = av;
    p2h_p_full  = fu;
  endtask

  // Advance one active (falling) edge and settle before sampling.
  task automatic tick();
    @(negedge h_phi2);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " obm"},  int'(one_byte_mode), 1);
    chk({tag, " dir"},  int'(dir_h2p), 0);
    chk({tag, " nmi"},  int'(p_nmi), 0);
    chk({tag, " busy"}, int'(busy), 0);
    chk({tag, " done"}, int'(done), 0);
    chk({tag, " cnt"},  int'(byte_cnt), 0);
  endtask

  initial begin
    int  seen_done;
    string nm;

    //          we typ ab sel web av fu | obm chk dir nmi busy done cnt
    vecs[0]  = '{1, 7, 0, 0, 1, 0, 0,   1, 1, 1, 0, 1, 0, 0};
    vecs[1]  = '{0, 0, 0, 0, 1, 1, 0,   1, 1, 1, 1, 1, 0, 0};
    vecs[2]  = '{0, 0, 0, 1, 0, 0, 0,   1, 1, 1, 0, 1, 0, 1};
    vecs[3]  = '{0, 0, 0, 1, 1, 1, 0,   1, 1, 1, 1, 1, 0, 1};
    vecs[4]  = '{1, 2, 0, 1, 0, 0, 0,   0, 1, 0, 1, 1, 0, 0};
    vecs[5]  = '{0, 0, 0, 0, 1, 0, 1,   0, 1, 0, 0, 1, 0, 0};
    vecs[6]  = '{0, 0, 0, 1, 1, 0, 1,   0, 1, 0, 0, 1, 0, 1};
    vecs[7]  = '{1, 3, 0, 1, 1, 0, 0,   0, 1, 1, 0, 1, 0, 0};
    vecs[8]  = '{0, 0, 0, 1, 0, 1, 0,   0, 1, 1, 1, 1, 0, 1};
    vecs[9]  = '{1, 5, 0, 0, 1, 1, 0,   0, 0, 1, 0, 0, 0, 0};
    vecs[10] = '{0, 0, 0, 1, 0, 1, 0,   0, 0, 1, 0, 0, 0, 0};
    vecs[11] = '{1, 1, 0, 0, 1, 1, 0,   1, 1, 1, 1, 1, 0, 0};
    vecs[12] = '{1, 4, 0, 0, 1, 1, 0,   0, 0, 0, 0, 0, 0, 0};
    vecs[13] = '{0, 0, 0, 1, 0, 1, 0,   0, 0, 0, 0, 0, 0, 0};
    vecs[14] = '{0, 0, 1, 0, 1, 1, 0,   0, 0, 0, 0, 0, 0, 0};
    vecs[15] = '{1, 1, 1, 0, 1, 1, 0,   0, 0, 0, 0, 0, 0, 0};
    vecs[16] = '{1, 0, 0, 0, 1, 0, 0,   1, 1, 0, 1, 1, 0, 0};
    vecs[17] = '{0, 0, 0, 1, 1, 0, 0,   1, 1, 0, 1, 1, 0, 1};
    vecs[18] = '{0, 0, 1, 1, 1, 0, 0,   1, 0, 0, 0, 0, 0, 1};

    // ---------------- reset ----------------
    h_rst_b = 1'b0;
    drive(0, 0, 0, 0, 1, 0, 0);
    tick();
    tick();
    chk_reset_vals("reset");
    #2 h_rst_b = 1'b1;
    tick();
    chk_reset_vals("post-reset idle");

    // ---------------- table vectors ----------------
    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].we, vecs[i].typ, vecs[i].ab, vecs[i].sel, vecs[i].web,
            vecs[i].av, vecs[i].fu);
      tick();
      nm = $sformatf("vec%0d", i);
      if (vecs[i].chk_obm) chk({nm, " obm"}, int'(one_byte_mode), int'(vecs[i].e_obm));
      chk({nm, " dir"},  int'(dir_h2p), int'(vecs[i].e_dir));
      chk({nm, " nmi"},  int'(p_nmi), int'(vecs[i].e_nmi));
      chk({nm, " busy"}, int'(busy), int'(vecs[i].e_busy));
      chk({nm, " done"}, int'(done), int'(vecs[i].e_done));
      chk({nm, " cnt"},  int'(byte_cnt), vecs[i].e_cnt);
    end

    // ---------------- type 7 block of host writes ----------------
    drive(1, 7, 0, 0, 1, 0, 0);
    tick();
    seen_done = 0;
`ifdef TUBE_R3_BLOCK_COUNT_EN
    for (int i = 1; i <= 256; i++) begin
      drive(0, 0, 0, 1, 0, 1, 0);
      tick();
      if (i < 256) begin
        chk("blk cnt", int'(byte_cnt), i);
        if (done) seen_done++;
      end
    end
    chk("blk final cnt", int'(byte_cnt), 256);
    chk("blk final done", int'(done), 1);
    chk("blk final busy", int'(busy), 0);
    chk("blk final nmi", int'(p_nmi), 0);
    chk("blk early done", seen_done, 0);
    tick();
    chk("blk after done", int'(done), 0);
    chk("blk after cnt", int'(byte_cnt), 256);
    chk("blk after busy", int'(busy), 0);
`else
    for (int i = 1; i <= 300; i++) begin
      drive(0, 0, 0, 1, 0, 1, 0);
      tick();
      if (done) seen_done++;
    end
    chk("nblk cnt", int'(byte_cnt), 300);
    chk("nblk done seen", seen_done, 0);
    chk("nblk busy", int'(busy), 1);
    chk("nblk dir", int'(dir_h2p), 1);
`endif

    // ---------------- saturation on type 1 ----------------
    drive(1, 1, 0, 0, 1, 0, 0);
    tick();
    for (int i = 1; i <= 520; i++) begin
      drive(0, 0, 0, 1, 0, 0, 0);
      tick();
    end
    chk("sat cnt", int'(byte_cnt), 511);
    chk("sat busy", int'(busy), 1);

    // ---------------- type 6, abort at count 100 ----------------
    drive(1, 6, 0, 0, 1, 0, 0);
    tick();
    chk("t6 dir", int'(dir_h2p), 0);
    chk("t6 obm", int'(one_byte_mode), 1);
    seen_done = 0;
    for (int i = 1; i <= 100; i++) begin
      drive(0, 0, 0, 1, 1, 0, 0);
      tick();
      if (done) seen_done++;
    end
    chk("t6 cnt100", int'(byte_cnt), 100);
    drive(0, 0, 1, 1, 1, 0, 0);
    tick();
    if (done) seen_done++;
    chk("abort busy", int'(busy), 0);
    chk("abort cnt", int'(byte_cnt), 100);
    chk("abort nmi", int'(p_nmi), 0);
    drive(0, 0, 0, 1, 1, 0, 0);
    tick();
    if (done) seen_done++;
    chk("abort cnt hold", int'(byte_cnt), 100);
    chk("abort no done", seen_done, 0);

    // ---------------- async reset mid type 7 ----------------
    drive(1, 7, 0, 0, 1, 1, 0);
    tick();
    for (int i = 1; i <= 200; i++) begin
      drive(0, 0, 0, 1, 0, 1, 0);
      tick();
    end
    chk("pre-rst cnt", int'(byte_cnt), 200);
    chk("pre-rst nmi", int'(p_nmi), 1);
    #2 h_rst_b = 1'b0;
    #1;
    chk_reset_vals("async rst");
    tick();
    chk_reset_vals("rst held");
    #2 h_rst_b = 1'b1;
    drive(0, 0, 0, 0, 1, 0, 0);
    tick();
    chk("rst release busy", int'(busy), 0);
    chk("rst release done", int'(done), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_tube_r3_xfer_ctrl

`default_nettype wire

// File: doc/tube_r3_xfer_ctrl.md
# tube_r3_xfer_ctrl

Host-clocked sequencer for the Tube register-3 data channel. It decodes the transfer type written by the host, then drives the FIFO's byte mode and transfer direction. It raises the parasite NMI whenever the FIFO needs service, counts bytes on 256-byte block transfers and signals completion. It sits beside the register-3 FIFOs and feeds their `one_byte_mode` input.

## Interface
Parameters:
- `BLOCK_LEN`, default 256: bytes in a type-6/7 block transfer, range 2..256.

Ports:
- `h_phi2`  in  1  host clock; all state updates on the falling edge.
- `h_rst_b`  in  1  reset, asynchronous, active-low.
- `h_cfg_we`  in  1  host strobe: write transfer type, sampled at negedge `h_phi2`.
- `h_cfg_type`  in  3  transfer type, 0..7.
- `h_abort`  in  1  terminates the active transfer; return to IDLE.
- `h_r3_sel`  in  1  host register-3 access this cycle.
- `h_we_b`  in  1  host access direction (0 = write).
- `h2p_p_avail`  in  1  host→parasite FIFO data available (parasite view).
- `p2h_p_full`  in  1  parasite→host FIFO full (parasite view).
- `one_byte_mode`  out  1  FIFO byte mode (V flag).
- `dir_h2p`  out  1  1 = host→parasite, 0 = parasite→host.
- `p_nmi`  out  1  parasite NMI request, active-high.
- `busy`  out  1  transfer in progress (RUN).
- `done`  out  1  one-cycle pulse at block completion.
- `byte_cnt`  out  9  host-side bytes moved in the current transfer.

## Operation
States:
- `IDLE`: NMI masked.
- `RUN`: transfer active.
- `EXEC`: type 4 only; no data moves.

Type decode on `h_cfg_we`, accepted in any state:
- 0: P→H, 1-byte.
- 1: H→P, 1-byte.
- 2: P→H, 2-byte.
- 3: H→P, 2-byte.
- 4: EXEC.
- 5: illegal; forces IDLE.
- 6: P→H, block.
- 7: H→P, block.

Type write effects:
- `one_byte_mode` = 1 for types 0, 1, 6, 7; 0 for types 2, 3.
- `dir_h2p` = 1 for odd types; 0 for types 0, 2, 6.
- Next state RUN for 0–3 and 6–7, EXEC for 4, IDLE for 5.
- `byte_cnt` cleared to 0.

`p_nmi` in RUN:
- `dir_h2p`=1: `p_nmi` = `h2p_p_avail`.
- `dir_h2p`=0: `p_nmi` = !`p2h_p_full`.

`p_nmi` = 0 in IDLE and EXEC.

Counting:
- `byte_cnt` increments on each cycle with `h_r3_sel` in RUN.
- Host access must match direction: write when `dir_h2p`=1, read when `dir_h2p`=0. Mismatched accesses are ignored.
- Saturates at 511.

Completion (types 6/7): when `byte_cnt` reaches `BLOCK_LEN`:
- `done` pulses.
- State returns to IDLE.
- `byte_cnt` holds its final value.

Types 0–3 stay in RUN until `h_abort` or a new type write. EXEC leaves only on `h_abort` or a new type write.

## Timing
Reset values:
- state IDLE.
- `one_byte_mode`=1.
- `dir_h2p`=0.
- `p_nmi`=0.
- `busy`=0.
- `done`=0.
- `byte_cnt`=0.

Latency and registering:
- All outputs registered at negedge `h_phi2`.
- Type write → new mode, direction and state visible after that edge (1-cycle latency).
- `p_nmi` is a registered copy of the FIFO flags: 1 cycle behind them.
- `done` is high for exactly one `h_phi2` cycle, registered together with the IDLE transition.

Simultaneous events in one cycle, by priority:
1. `h_abort` wins over everything else.
2. A type write beats a counting access; the count restarts at 0.
3. The final counting access and completion happen together: `byte_cnt`=`BLOCK_LEN` and `done`=1 in the same cycle.

Reset mid-transfer: `h_rst_b` low asynchronously forces all reset values; no `done` pulse.

## Configuration
`TUBE_R3_BLOCK_COUNT_EN`:
- Defined: block counting and automatic completion are enabled for types 6/7 as above.
- Not defined: types 6/7 behave like types 0/1, except `dir_h2p` follows the type. `done` is tied to 0. `byte_cnt` still counts and saturates.

## Structure
Shared package `tube_pkg`:
- transfer type localparams: `XFER_P2H1` .. `XFER_H2P256`.
- state encodings: `ST_IDLE`, `ST_RUN`, `ST_EXEC`.

Sub-module `tube_r3_type_dec`: combinational decode of type → {`one_byte_mode`, `dir_h2p`, next state, is_block}. The FSM, counter and NMI logic stay in the top module.

## Test plan
- Reset, then write type 7 → after 1 cycle: `one_byte_mode`=1, `dir_h2p`=1, `busy`=1, `byte_cnt`=0. `p_nmi` follows `h2p_p_avail` with 1-cycle delay.
- Type 7 with 256 host writes → `byte_cnt`=256, `done`=1 for one cycle on the 256th, then `busy`=0 and `p_nmi`=0.
- Type 2 with `p2h_p_full`=0 → `p_nmi`=1, `one_byte_mode`=0, `dir_h2p`=0. Raise `p2h_p_full` → `p_nmi`=0 one cycle later.
- Type 6 at count 100, then `h_abort` together with a host read → IDLE, `byte_cnt` stays 100, no `done`.
- Type 5 written during RUN → IDLE, `p_nmi`=0. Type 4 → EXEC, `busy`=0, `p_nmi`=0.
- `h_rst_b` pulsed low at count 200 of type 7 → all outputs at reset values immediately. Without `TUBE_R3_BLOCK_COUNT_EN`: type 7 with 300 writes → `done` never asserts, `byte_cnt`=300.
